// File: rtl/m_axis_rx_arbiter.sv
// m_axis_rx_arbiter: merges CQ and RC AXI-Stream packets onto one RX stream without interleaving packets.
// Latency: 1 cycle from input acceptance to output, with full throughput through a single output register.
// Backpressure: the granted source's tready = !out_valid || m_axis_rx_tready. M_AXIS_RX_ARB_CQ_PRIO_EN selects strict CQ priority.
module m_axis_rx_arbiter #(
    parameter int DATA_WIDTH = 128,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int USER_WIDTH = 22
) (
    input  logic                  user_clk,
    input  logic                  user_reset,

    input  logic [DATA_WIDTH-1:0] s_axis_cq_tdata,
    input  logic [KEEP_WIDTH-1:0] s_axis_cq_tkeep,
    input  logic                  s_axis_cq_tlast,
    input  logic [USER_WIDTH-1:0] s_axis_cq_tuser,
    input  logic                  s_axis_cq_tvalid,
    output logic                  s_axis_cq_tready,

    input  logic [DATA_WIDTH-1:0] s_axis_rc_tdata,
    input  logic [KEEP_WIDTH-1:0] s_axis_rc_tkeep,
    input  logic                  s_axis_rc_tlast,
    input  logic [USER_WIDTH-1:0] s_axis_rc_tuser,
    input  logic                  s_axis_rc_tvalid,
    output logic                  s_axis_rc_tready,

    output logic [DATA_WIDTH-1:0] m_axis_rx_tdata,
    output logic [KEEP_WIDTH-1:0] m_axis_rx_tkeep,
    output logic                  m_axis_rx_tlast,
    output logic [USER_WIDTH-1:0] m_axis_rx_tuser,
    output logic                  m_axis_rx_tvalid,
    input  logic                  m_axis_rx_tready,
    output logic                  m_axis_rx_tsrc
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GNT_CQ = 2'd1,
        GNT_RC = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic                  in_pkt_q, in_pkt_d;
    logic                  out_valid_q, out_valid_d;
    logic                  out_last_q, out_last_d;
    logic                  out_src_q, out_src_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic [KEEP_WIDTH-1:0] out_keep_q, out_keep_d;
    logic [USER_WIDTH-1:0] out_user_q, out_user_d;

    logic                  gnt_rc;
    logic                  sel_vld;
    logic                  sel_last;
    logic [DATA_WIDTH-1:0] sel_data;
    logic [KEEP_WIDTH-1:0] sel_keep;
    logic [USER_WIDTH-1:0] sel_user;
    logic                  cq_acc;
    logic                  rc_acc;
    logic                  acc;
    logic                  any_vld;
    logic                  rc_wins_idle;
    logic                  rc_wins_last;

    assign s_axis_cq_tready = (state_q == GNT_CQ) && (!out_valid_q || m_axis_rx_tready);
    assign s_axis_rc_tready = (state_q == GNT_RC) && (!out_valid_q || m_axis_rx_tready);

    assign cq_acc  = s_axis_cq_tvalid && s_axis_cq_tready;
    assign rc_acc  = s_axis_rc_tvalid && s_axis_rc_tready;
    assign acc     = cq_acc || rc_acc;
    assign any_vld = s_axis_cq_tvalid || s_axis_rc_tvalid;
    assign gnt_rc  = (state_q == GNT_RC);

    assign sel_vld  = gnt_rc ? s_axis_rc_tvalid : s_axis_cq_tvalid;
    assign sel_last = gnt_rc ? s_axis_rc_tlast  : s_axis_cq_tlast;
    assign sel_data = gnt_rc ? s_axis_rc_tdata  : s_axis_cq_tdata;
    assign sel_keep = gnt_rc ? s_axis_rc_tkeep  : s_axis_cq_tkeep;
    assign sel_user = gnt_rc ? s_axis_rc_tuser  : s_axis_cq_tuser;

`ifdef M_AXIS_RX_ARB_CQ_PRIO_EN
    assign rc_wins_idle = !s_axis_cq_tvalid;
    assign rc_wins_last = !s_axis_cq_tvalid;
`else
    logic last_grant_q, last_grant_d;

    // last_grant = 1 means RC finished most recently, so CQ wins the next tie.
    assign rc_wins_idle = s_axis_rc_tvalid && (!s_axis_cq_tvalid || !last_grant_q);
    assign rc_wins_last = s_axis_rc_tvalid && (!s_axis_cq_tvalid || !gnt_rc);
`endif

    always_comb begin
        state_d  = state_q;
        in_pkt_d = in_pkt_q;
`ifndef M_AXIS_RX_ARB_CQ_PRIO_EN
        last_grant_d = last_grant_q;
`endif
        case (state_q)
            GNT_CQ, GNT_RC: begin
                if (acc && sel_last) begin
                    in_pkt_d = 1'b0;
`ifndef M_AXIS_RX_ARB_CQ_PRIO_EN
                    last_grant_d = gnt_rc;
`endif
                    if (any_vld) state_d = rc_wins_last ? GNT_RC : GNT_CQ;
                    else         state_d = IDLE;
                end else if (acc) begin
                    in_pkt_d = 1'b1;
                end else if (!in_pkt_q && !sel_vld) begin
                    // Grant parked on a packet boundary with its source gone idle: re-arbitrate.
                    state_d = IDLE;
                end
            end
            default: begin
                if (any_vld) state_d = rc_wins_idle ? GNT_RC : GNT_CQ;
                else         state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        out_valid_d = acc || (out_valid_q && !m_axis_rx_tready);
        out_last_d  = acc ? sel_last : out_last_q;
        out_src_d   = acc ? gnt_rc   : out_src_q;
        out_data_d  = acc ? sel_data : out_data_q;
        out_keep_d  = acc ? sel_keep : out_keep_q;
        out_user_d  = acc ? sel_user : out_user_q;
    end

    always_ff @(posedge user_clk or posedge user_reset) begin
        if (user_reset) begin
            state_q     <= IDLE;
            in_pkt_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_src_q   <= 1'b0;
`ifndef M_AXIS_RX_ARB_CQ_PRIO_EN
            last_grant_q <= 1'b1;
`endif
        end else begin
            state_q     <= state_d;
            in_pkt_q    <= in_pkt_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_src_q   <= out_src_d;
`ifndef M_AXIS_RX_ARB_CQ_PRIO_EN
            last_grant_q <= last_grant_d;
`endif
        end
    end

    // Payload is qualified by out_valid, so it carries no reset.
    always_ff @(posedge user_clk) begin
        out_data_q <= out_data_d;
        out_keep_q <= out_keep_d;
        out_user_q <= out_user_d;
    end

    assign m_axis_rx_tvalid = out_valid_q;
    assign m_axis_rx_tlast  = out_last_q;
    assign m_axis_rx_tsrc   = out_src_q;
    assign m_axis_rx_tdata  = out_data_q;
    assign m_axis_rx_tkeep  = out_keep_q;
    assign m_axis_rx_tuser  = out_user_q;

endmodule
